// File: rtl/bru_bpu_update_pkg.sv
// bru_bpu_update_pkg: shared branch-type enum, update-queue entry and widths
package bru_bpu_update_pkg;
    localparam int PC_W = 64;
    typedef enum logic [2:0] {BT_NONE, BT_BR, BT_JAL, BT_JALR, BT_CALL, BT_RET} br_type_e;
    typedef struct packed {
        logic [PC_W-1:0] pc;
        br_type_e        typ;
        logic [PC_W-1:0] target;
        logic            taken;
    } upd_entry_t;
endpackage

// File: rtl/bru_bpu_update_if.sv
// bru_bpu_update_if: execute-side resolve bus, BTB update bus and fetch redirect
interface bru_bpu_update_if;
    import bru_bpu_update_pkg::*;
    logic            ex_vld;
    logic            ex_ready;
    logic [PC_W-1:0] ex_pc;
    br_type_e        ex_type;
    logic            ex_taken;
    logic [PC_W-1:0] ex_target;
    logic            ex_pred_hit;
    logic            ex_pred_taken;
    logic [PC_W-1:0] ex_pred_pc;
    logic            alu_bpu_wr_req;
    logic            bpu_alu_wr_ready;
    logic [PC_W-1:0] alu_bpu_wr_pc;
    br_type_e        alu_bpu_wr_type;
    logic [PC_W-1:0] alu_bpu_wr_predict_pc;
    logic            alu_bpu_wr_predict_taken;
    logic            alu_bpu_jump_en;
    logic [PC_W-1:0] alu_ifu_redirect_pc;
    modport slave (
        input  ex_vld, ex_pc, ex_type, ex_taken, ex_target, ex_pred_hit, ex_pred_taken, ex_pred_pc,
        input  bpu_alu_wr_ready,
        output ex_ready, alu_bpu_wr_req, alu_bpu_wr_pc, alu_bpu_wr_type, alu_bpu_wr_predict_pc,
        output alu_bpu_wr_predict_taken, alu_bpu_jump_en, alu_ifu_redirect_pc
    );
    modport master (
        output ex_vld, ex_pc, ex_type, ex_taken, ex_target, ex_pred_hit, ex_pred_taken, ex_pred_pc,
        output bpu_alu_wr_ready,
        input  ex_ready, alu_bpu_wr_req, alu_bpu_wr_pc, alu_bpu_wr_type, alu_bpu_wr_predict_pc,
        input  alu_bpu_wr_predict_taken, alu_bpu_jump_en, alu_ifu_redirect_pc
    );
endinterface

// File: rtl/bpu_upd_fifo.sv
// bpu_upd_fifo: valid/ready FIFO of BTB update entries, zero payload when empty
module bpu_upd_fifo
    import bru_bpu_update_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       in_vld,
    output logic       in_ready,
    input  upd_entry_t in_data,
    output logic       out_vld,
    input  logic       out_ready,
    output upd_entry_t out_data
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = DEPTH[AW:0];
    upd_entry_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt;
    logic          push, pop;
    assign in_ready = cnt < FULL;
    assign out_vld  = cnt != '0;
    assign push     = in_vld & in_ready;
    assign pop      = out_vld & out_ready;
    assign out_data = out_vld ? mem[rd_ptr] : '0;
    // pointers wrap naturally at the power-of-two depth; count tracks occupancy
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push & ~pop) cnt <= cnt + 1'b1;
            else if (pop & ~push) cnt <= cnt - 1'b1;
        end
    end
    // storage needs no reset: reads are masked while empty
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end
endmodule

// File: rtl/bru_bpu_update.sv
// bru_bpu_update: resolves branches, flushes on mispredict and queues BTB updates
module bru_bpu_update
    import bru_bpu_update_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rstn,
    bru_bpu_update_if.slave  bus,
    output logic [CNT_W-1:0] perf_br_cnt,
    output logic [CNT_W-1:0] perf_mispred_cnt
);
    logic            live, is_br, enq, mis, jump_q;
    logic [PC_W-1:0] seq_pc, actual_npc, pred_npc, redirect_q;
    upd_entry_t      head;
    assign seq_pc     = bus.ex_pc + 64'd4;
    assign actual_npc = bus.ex_taken ? bus.ex_target : seq_pc;
    assign pred_npc   = (bus.ex_pred_hit & bus.ex_pred_taken) ? bus.ex_pred_pc : seq_pc;
    // transfers arriving while the flush pulse is out are wrong-path and dropped
    assign live  = bus.ex_vld & bus.ex_ready & ~jump_q;
    assign is_br = bus.ex_type != BT_NONE;
    assign enq   = live & is_br;
    assign mis   = enq & (actual_npc != pred_npc);
    bpu_upd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .in_vld   (enq),
        .in_ready (bus.ex_ready),
        .in_data  ('{pc: bus.ex_pc, typ: bus.ex_type, target: bus.ex_target, taken: bus.ex_taken}),
        .out_vld  (bus.alu_bpu_wr_req),
        .out_ready(bus.bpu_alu_wr_ready),
        .out_data (head)
    );
    assign bus.alu_bpu_wr_pc            = head.pc;
    assign bus.alu_bpu_wr_type          = head.typ;
    assign bus.alu_bpu_wr_predict_pc    = head.target;
    assign bus.alu_bpu_wr_predict_taken = head.taken;
    assign bus.alu_bpu_jump_en          = jump_q;
    assign bus.alu_ifu_redirect_pc      = redirect_q;
    // one-cycle flush pulse; redirect PC held at zero outside the pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            jump_q     <= 1'b0;
            redirect_q <= '0;
        end else begin
            jump_q     <= mis;
            redirect_q <= mis ? actual_npc : '0;
        end
    end
    // saturating branch and mispredict counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_br_cnt      <= '0;
            perf_mispred_cnt <= '0;
        end else begin
            if (enq && !(&perf_br_cnt)) perf_br_cnt <= perf_br_cnt + 1'b1;
            if (mis && !(&perf_mispred_cnt)) perf_mispred_cnt <= perf_mispred_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_bru_bpu_update.sv
// tb_bru_bpu_update: directed bench with scoreboard for the BTB update stream
module tb_bru_bpu_update;
    import bru_bpu_update_pkg::*;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [3:0] br_cnt, mis_cnt;
    int         n_tests = 0;
    int         n_fail = 0;
    upd_entry_t sb [$];
    bru_bpu_update_if bus ();
    bru_bpu_update #(.FIFO_DEPTH(4), .CNT_W(4)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .bus             (bus),
        .perf_br_cnt     (br_cnt),
        .perf_mispred_cnt(mis_cnt)
    );
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input br_type_e t, input logic [63:0] pc, input logic tk, input logic [63:0] tg,
                        input logic hit, input logic pt, input logic [63:0] ppc);
        bus.ex_vld = 1'b1;
        bus.ex_type = t;
        bus.ex_pc = pc;
        bus.ex_taken = tk;
        bus.ex_target = tg;
        bus.ex_pred_hit = hit;
        bus.ex_pred_taken = pt;
        bus.ex_pred_pc = ppc;
    endtask

    task automatic push(input logic [63:0] pc, input br_type_e t, input logic [63:0] tg, input logic tk);
        upd_entry_t e;
        e.pc = pc;
        e.typ = t;
        e.target = tg;
        e.taken = tk;
        sb.push_back(e);
    endtask

    // update accepted at the coming edge must match the scoreboard head
    always @(negedge clk) begin
        if (rstn && bus.alu_bpu_wr_req && bus.bpu_alu_wr_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_update", bus.alu_bpu_wr_pc, 64'hdead);
            end else begin
                upd_entry_t e;
                e = sb.pop_front();
                chk("sb_wr_pc", bus.alu_bpu_wr_pc, e.pc);
                chk("sb_wr_type", 64'(bus.alu_bpu_wr_type), 64'(e.typ));
                chk("sb_wr_predict_pc", bus.alu_bpu_wr_predict_pc, e.target);
                chk("sb_wr_predict_taken", 64'(bus.alu_bpu_wr_predict_taken), 64'(e.taken));
            end
        end
    end

    initial begin
        bus.ex_vld = 1'b0;
        bus.ex_type = BT_NONE;
        bus.ex_pc = '0;
        bus.ex_taken = 1'b0;
        bus.ex_target = '0;
        bus.ex_pred_hit = 1'b0;
        bus.ex_pred_taken = 1'b0;
        bus.ex_pred_pc = '0;
        bus.bpu_alu_wr_ready = 1'b1;
        #3;
        chk("rst_wr_req", 64'(bus.alu_bpu_wr_req), 0);
        chk("rst_jump_en", 64'(bus.alu_bpu_jump_en), 0);
        chk("rst_wr_pc", bus.alu_bpu_wr_pc, 0);
        chk("rst_redirect", bus.alu_ifu_redirect_pc, 0);
        chk("rst_br_cnt", 64'(br_cnt), 0);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        chk("rst_ex_ready", 64'(bus.ex_ready), 1);
        // correctly predicted taken branch
        send(BT_BR, 64'h1000, 1'b1, 64'h1080, 1'b1, 1'b1, 64'h1080);
        push(64'h1000, BT_BR, 64'h1080, 1'b1);
        tick();
        bus.ex_vld = 1'b0;
        chk("t1_jump_en", 64'(bus.alu_bpu_jump_en), 0);
        chk("t1_wr_req", 64'(bus.alu_bpu_wr_req), 1);
        chk("t1_br_cnt", 64'(br_cnt), 1);
        chk("t1_mis_cnt", 64'(mis_cnt), 0);
        tick();
        chk("t1_empty_wr_req", 64'(bus.alu_bpu_wr_req), 0);
        chk("t1_empty_wr_pc", bus.alu_bpu_wr_pc, 0);
        // predicted taken, actually not taken
        send(BT_BR, 64'h2000, 1'b0, 64'h2040, 1'b1, 1'b1, 64'h2040);
        push(64'h2000, BT_BR, 64'h2040, 1'b0);
        tick();
        bus.ex_vld = 1'b0;
        chk("t2_jump_en", 64'(bus.alu_bpu_jump_en), 1);
        chk("t2_redirect", bus.alu_ifu_redirect_pc, 64'h2004);
        chk("t2_mis_cnt", 64'(mis_cnt), 1);
        chk("t2_br_cnt", 64'(br_cnt), 2);
        tick();
        chk("t2_jump_clear", 64'(bus.alu_bpu_jump_en), 0);
        chk("t2_redirect_clear", bus.alu_ifu_redirect_pc, 0);
        // mispredict followed by a wrong-path JAL in the flush cycle
        send(BT_BR, 64'h3000, 1'b1, 64'h3100, 1'b0, 1'b0, 64'h0);
        push(64'h3000, BT_BR, 64'h3100, 1'b1);
        tick();
        send(BT_JAL, 64'h4000, 1'b1, 64'h5000, 1'b0, 1'b0, 64'h0);
        chk("t3_jump_en", 64'(bus.alu_bpu_jump_en), 1);
        chk("t3_redirect", bus.alu_ifu_redirect_pc, 64'h3100);
        tick();
        bus.ex_vld = 1'b0;
        chk("t3_no_second_jump", 64'(bus.alu_bpu_jump_en), 0);
        chk("t3_br_cnt", 64'(br_cnt), 3);
        chk("t3_mis_cnt", 64'(mis_cnt), 2);
        tick();
        // non-branch never mispredicts nor enqueues
        send(BT_NONE, 64'h6000, 1'b1, 64'h7000, 1'b0, 1'b0, 64'h0);
        tick();
        bus.ex_vld = 1'b0;
        chk("t4_none_jump", 64'(bus.alu_bpu_jump_en), 0);
        chk("t4_none_wr_req", 64'(bus.alu_bpu_wr_req), 0);
        chk("t4_none_br_cnt", 64'(br_cnt), 3);
        // back-pressure: fill the queue, fifth is refused
        bus.bpu_alu_wr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(BT_BR, 64'h8000 + 64'(i * 16), 1'b0, 64'h9000, 1'b0, 1'b0, 64'h0);
            chk("t5_ex_ready", 64'(bus.ex_ready), (i < 4) ? 64'd1 : 64'd0);
            if (i < 4) push(64'h8000 + 64'(i * 16), BT_BR, 64'h9000, 1'b0);
            tick();
        end
        bus.ex_vld = 1'b0;
        chk("t5_full_ready", 64'(bus.ex_ready), 0);
        chk("t5_full_br_cnt", 64'(br_cnt), 7);
        bus.bpu_alu_wr_ready = 1'b1;
        tick();
        chk("t5_ready_back", 64'(bus.ex_ready), 1);
        repeat (3) tick();
        chk("t5_drained", 64'(bus.alu_bpu_wr_req), 0);
        // sequential PC wraps at the top of the address space
        send(BT_BR, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h1234, 1'b1, 1'b1, 64'h1234);
        push(64'hFFFF_FFFF_FFFF_FFFC, BT_BR, 64'h1234, 1'b0);
        tick();
        bus.ex_vld = 1'b0;
        chk("t6_jump_en", 64'(bus.alu_bpu_jump_en), 1);
        chk("t6_redirect_wrap", bus.alu_ifu_redirect_pc, 64'h0);
        chk("t6_mis_cnt", 64'(mis_cnt), 3);
        tick();
        // branch counter saturates at all-ones
        for (int i = 0; i < 20; i++) begin
            send(BT_JALR, 64'hA000 + 64'(i * 4), 1'b1, 64'hB000, 1'b1, 1'b1, 64'hB000);
            push(64'hA000 + 64'(i * 4), BT_JALR, 64'hB000, 1'b1);
            tick();
        end
        bus.ex_vld = 1'b0;
        tick();
        chk("t7_br_sat", 64'(br_cnt), 15);
        chk("t7_mis_hold", 64'(mis_cnt), 3);
        // asynchronous reset drops queued updates
        bus.bpu_alu_wr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(BT_BR, 64'hC000 + 64'(i * 4), 1'b0, 64'hD000, 1'b0, 1'b0, 64'h0);
            tick();
        end
        bus.ex_vld = 1'b0;
        chk("t8_queued", 64'(bus.alu_bpu_wr_req), 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("t8_async_wr_req", 64'(bus.alu_bpu_wr_req), 0);
        chk("t8_async_wr_pc", bus.alu_bpu_wr_pc, 0);
        chk("t8_async_br_cnt", 64'(br_cnt), 0);
        @(negedge clk);
        rstn = 1'b1;
        bus.bpu_alu_wr_ready = 1'b1;
        tick();
        chk("t8_post_ready", 64'(bus.ex_ready), 1);
        chk("t8_post_wr_req", 64'(bus.alu_bpu_wr_req), 0);
        chk("t8_post_mis_cnt", 64'(mis_cnt), 0);
        repeat (2) tick();
        chk("sb_leftover", 64'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bru_bpu_update.md
BRU_BPU_UPDATE -- requirements
Module: bru_bpu_update

Interface
REQ-001 Parameters: FIFO_DEPTH, default 4, update-queue entries (power of 2, >=2); CNT_W, default 32, perf counter width.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rstn  in  1  reset, asynchronous, active-low.
REQ-004 ex_vld  in  1  resolved instruction from execute stage valid.
REQ-005 ex_ready  out  1  block accepts ex_* this cycle; transfer = ex_vld & ex_ready.
REQ-006 ex_pc  in  64  instruction PC.
REQ-007 ex_type  in  3  branch type (package enum; NONE = non-branch).
REQ-008 ex_taken  in  1  actual direction (1 for unconditional types).
REQ-009 ex_target  in  64  actual target when taken.
REQ-010 ex_pred_hit / ex_pred_taken / ex_pred_pc  in  1/1/64  prediction carried from IFU (bpu_ifu_predict_*).
REQ-011 alu_bpu_wr_req  out  1  BTB update request; holds until accepted.
REQ-012 bpu_alu_wr_ready  in  1  BPU accepts update when high with wr_req.
REQ-013 alu_bpu_wr_pc / alu_bpu_wr_type / alu_bpu_wr_predict_pc / alu_bpu_wr_predict_taken  out  64/3/64/1  update payload.
REQ-014 alu_bpu_jump_en  out  1  one-cycle mispredict flush pulse.
REQ-015 alu_ifu_redirect_pc  out  64  correct fetch PC, valid with jump_en.
REQ-016 perf_br_cnt / perf_mispred_cnt  out  CNT_W/CNT_W  branch and mispredict counters.

Function
REQ-017 ex_ready SHALL equal (queue count < FIFO_DEPTH); no same-cycle bypass of a dequeue.
REQ-018 seq_pc = ex_pc + 4 (64-bit, wraps modulo 2^64); actual_npc = ex_taken ? ex_target : seq_pc; pred_npc = (ex_pred_hit & ex_pred_taken) ? ex_pred_pc : seq_pc.
REQ-019 mispredict SHALL be asserted for an accepted transfer when ex_type != NONE and actual_npc != pred_npc; ex_type == NONE never mispredicts.
REQ-020 On mispredict accepted in cycle N, alu_bpu_jump_en SHALL be 1 in cycle N+1 only, with alu_ifu_redirect_pc = actual_npc; redirect is not gated by queue state.
REQ-021 Every accepted transfer with ex_type != NONE SHALL enqueue {ex_pc, ex_type, ex_target, ex_taken}; payload maps to wr_pc, wr_type, wr_predict_pc, wr_predict_taken.
REQ-022 alu_bpu_wr_req = queue non-empty; payload = head entry; head dequeues on wr_req & bpu_alu_wr_ready; minimum enqueue-to-wr_req latency 1 cycle; order strictly FIFO.
REQ-023 Simultaneous enqueue and dequeue SHALL leave count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-024 Wrong-path squash: a transfer accepted in the cycle alu_bpu_jump_en is 1 SHALL be discarded (no enqueue, no redirect, no counter change); queued entries are never squashed.
REQ-025 Back-to-back mispredicts in N and N+1 cannot both fire: the N+1 transfer is squashed per REQ-024.
REQ-026 perf_br_cnt increments per non-squashed enqueue; perf_mispred_cnt per non-squashed mispredict; both saturate at all-ones.
REQ-027 Payload outputs SHALL be zero when queue empty; redirect_pc SHALL be zero when jump_en is 0.

Reset
REQ-028 While rstn low: queue empty, pointers/count 0, wr_req 0, jump_en 0, all payload and redirect outputs 0, counters 0, ex_ready 1 after reset deassertion.
REQ-029 Reset asserted mid-operation SHALL drop all queued updates and any pending flush pulse immediately (asynchronous).

Structure
REQ-030 Branch-type enum (NONE, BR, JAL, JALR, CALL, RET), FIFO entry struct, and widths SHALL live in the shared bpu package used by btb and npc_generate.
REQ-031 Update queue SHALL be one sub-module bpu_upd_fifo (valid/ready, parameterised depth); mispredict/redirect logic and counters stay in the top.

Verification
REQ-032 BR at pc 0x1000, taken to 0x1080, pred_hit=1 pred_taken=1 pred_pc=0x1080 -> no jump_en; wr_req next cycle with pc 0x1000, type BR, predict_pc 0x1080, taken 1; perf_br_cnt=1.
REQ-033 BR at 0x2000 not taken, predicted taken to 0x2040 -> jump_en pulse 1 cycle, redirect_pc 0x2004, perf_mispred_cnt=1.
REQ-034 Mispredict in N, JAL presented in N+1 -> N+1 transfer squashed: no enqueue, no second jump_en, counters unchanged.
REQ-035 bpu_alu_wr_ready=0, 5 consecutive branches -> 4 accepted, ex_ready=0 on 5th; release ready -> 4 updates in order, ex_ready returns after first dequeue.
REQ-036 pc 0xFFFF_FFFF_FFFF_FFFC BR not taken, predicted taken -> redirect_pc 0x0.
REQ-037 Queue holding 3 entries, rstn pulsed low -> wr_req 0 same cycle, queue empty, counters 0 after release.
